// File: rtl/price_pkg.sv
// Shared types and the unit-price table for line_price_engine.
// Prices are 3-digit BCD (cents); unknown IDs read back as all-ones.
package price_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ADD,
    S_DONE
  } lpe_state_e;

  function automatic logic [31:0] price_lookup(input logic [31:0] id);
    logic [31:0] p;
    case (id)
      32'd0:   p = 32'h250;
      32'd1:   p = 32'h125;
      32'd2:   p = 32'h399;
      32'd3:   p = 32'h100;
      32'd4:   p = 32'h075;
      32'd5:   p = 32'h995;
      32'd6:   p = 32'h001;
      32'd7:   p = 32'h480;
      32'd8:   p = 32'h612;
      32'd9:   p = 32'h333;
      32'd10:  p = 32'h909;
      32'd11:  p = 32'h050;
      default: p = '1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of a ripple BCD adder: binary add then +6 correction.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
  end

endmodule

// File: rtl/line_price_engine.sv
// BCD line-price engine: unit price x quantity by shift-and-add, one digit at a time.
// Optional running subtotal enabled by `define LINE_PRICE_SUBTOTAL_EN.
module line_price_engine
  import price_pkg::*;
#(
  parameter int PRICE_DIGITS = 3,
  parameter int QTY_DIGITS   = 2,
  parameter int ID_W         = 4,
  parameter int N_PRODUCTS   = 12,
  parameter int SUB_DIGITS   = PRICE_DIGITS + QTY_DIGITS + 2
) (
  input  logic                                  CLK,
  input  logic                                  RESET_N,
  input  logic                                  START,
  input  logic [ID_W-1:0]                       ID,
  input  logic [4*QTY_DIGITS-1:0]               QTT,
  input  logic                                  CLEAR,
  output logic                                  BUSY,
  output logic                                  DONE,
  output logic                                  ERR,
  output logic [4*(PRICE_DIGITS+QTY_DIGITS)-1:0] PRICE,
  output logic [4*SUB_DIGITS-1:0]               SUBTOTAL,
  output logic                                  OVF
);

  localparam int UW = 4 * PRICE_DIGITS;
  localparam int QW = 4 * QTY_DIGITS;
  localparam int PD = PRICE_DIGITS + QTY_DIGITS;
  localparam int PW = 4 * PD;
  localparam int SW = 4 * SUB_DIGITS;
  localparam int CW = $clog2(QTY_DIGITS + 1);

  lpe_state_e      state, state_n;
  logic [ID_W-1:0] id_r, id_n;
  logic [QW-1:0]   qtt_r, qtt_n;
  logic [UW-1:0]   unit_r;
  logic [PW-1:0]   acc_r, acc_n, add_sum, unit_ext;
  logic [3:0]      cnt_r, cnt_n;
  logic [CW-1:0]   dig_r, dig_n;
  logic [PW-1:0]   price_r;
  logic            err_r;
  logic            qtt_bad, bad_req;
  logic [PD:0]     pc;
  logic            unused_pcarry;

  always_comb begin
    qtt_bad = 1'b0;
    for (int unsigned i = 0; i < QTY_DIGITS; i++)
      if (qtt_r[4*i +: 4] > 4'd9) qtt_bad = 1'b1;
  end

  assign bad_req = qtt_bad || (32'(id_r) >= 32'(N_PRODUCTS));

  // Product adder: accumulator + unit price, digit-serial carry chain
  assign unit_ext      = PW'(unit_r);
  assign pc[0]         = 1'b0;
  assign unused_pcarry = pc[PD];

  for (genvar g = 0; g < PD; g++) begin : g_prod
    bcd_digit_add u_add (
      .a   (acc_r[4*g +: 4]),
      .b   (unit_ext[4*g +: 4]),
      .cin (pc[g]),
      .sum (add_sum[4*g +: 4]),
      .cout(pc[g+1])
    );
  end

  always_comb begin
    state_n = state;
    id_n    = id_r;
    qtt_n   = qtt_r;
    acc_n   = acc_r;
    cnt_n   = cnt_r;
    dig_n   = dig_r;
    case (state)
      S_IDLE: begin
        if (START) begin
          id_n    = ID;
          qtt_n   = QTT;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_n   = '0;
        dig_n   = CW'(QTY_DIGITS);
        state_n = bad_req ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        // Consume the MSD: shift it out of qtt_r and into the add counter
        acc_n = acc_r << 4;
        cnt_n = qtt_r[QW-1 -: 4];
        qtt_n = qtt_r << 4;
        dig_n = dig_r - CW'(1);
        if (qtt_r[QW-1 -: 4] != 4'd0)
          state_n = S_ADD;
        else if (dig_r == CW'(1))
          state_n = S_DONE;
      end
      S_ADD: begin
        acc_n = add_sum;
        cnt_n = cnt_r - 4'd1;
        if (cnt_r == 4'd1)
          state_n = (dig_r == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      id_r    <= '0;
      qtt_r   <= '0;
      unit_r  <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      dig_r   <= '0;
      price_r <= '1;
      err_r   <= 1'b0;
    end else begin
      state <= state_n;
      id_r  <= id_n;
      qtt_r <= qtt_n;
      acc_r <= acc_n;
      cnt_r <= cnt_n;
      dig_r <= dig_n;
      if (state == S_LOAD)
        unit_r <= UW'(price_lookup(32'(id_r)));
      // Result lands in PRICE only on the transition into DONE
      if (state_n == S_DONE && state != S_DONE) begin
        price_r <= (state == S_LOAD) ? '1 : acc_n;
        err_r   <= (state == S_LOAD);
      end
    end
  end

  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_DONE);
  assign ERR   = (state == S_DONE) && err_r;
  assign PRICE = price_r;

`ifdef LINE_PRICE_SUBTOTAL_EN
  logic [SW-1:0]       sub_r, sub_sum, price_ext;
  logic [SUB_DIGITS:0] sc;
  logic                ovf_r;

  assign price_ext = SW'(price_r);
  assign sc[0]     = 1'b0;

  for (genvar g = 0; g < SUB_DIGITS; g++) begin : g_sub
    bcd_digit_add u_add (
      .a   (sub_r[4*g +: 4]),
      .b   (price_ext[4*g +: 4]),
      .cin (sc[g]),
      .sum (sub_sum[4*g +: 4]),
      .cout(sc[g+1])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sub_r <= '0;
      ovf_r <= 1'b0;
    end else if (CLEAR) begin
      sub_r <= '0;
      ovf_r <= 1'b0;
    end else if (state == S_DONE && !err_r) begin
      if (sc[SUB_DIGITS]) begin
        sub_r <= {SUB_DIGITS{4'h9}};
        ovf_r <= 1'b1;
      end else begin
        sub_r <= sub_sum;
      end
    end
  end

  assign SUBTOTAL = sub_r;
  assign OVF      = ovf_r;
`else
  logic unused_clear;
  assign unused_clear = CLEAR;
  assign SUBTOTAL     = '0;
  assign OVF          = 1'b0;
`endif

endmodule

// File: tb/tb_line_price_engine.sv
// Self-checking bench for line_price_engine: directed cases plus random lines
// against an integer-arithmetic reference model.
module tb_line_price_engine;

`ifdef LINE_PRICE_SUBTOTAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        CLK, RESET_N, START, CLEAR;
  logic [3:0]  ID;
  logic [7:0]  QTT;
  logic        BUSY, DONE, ERR, OVF;
  logic [19:0] PRICE, SUBTOTAL;

  int total = 0;
  int bad   = 0;
  int sub_m = 0;
  bit ovf_m = 1'b0;
  int tbl[12] = '{250, 125, 399, 100, 75, 995, 1, 480, 612, 333, 909, 50};

  line_price_engine #(.SUB_DIGITS(5)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .ID      (ID),
    .QTT     (QTT),
    .CLEAR   (CLEAR),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .PRICE   (PRICE),
    .SUBTOTAL(SUBTOTAL),
    .OVF     (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dec_of(input logic [31:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] bcd_of(input int x, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the engine idle.
  task automatic run_line(input logic [3:0] id, input logic [7:0] q,
                          input int pulse_at, input bit clr_at_done);
    bit          err, seen, busy_lost;
    int          dsum, exp_cyc, cyc;
    logic [31:0] exp_price;
    err  = (int'(id) >= 12);
    dsum = 0;
    for (int i = 0; i < 2; i++) begin
      if (q[4*i +: 4] > 4'd9) err = 1'b1;
      dsum += int'(q[4*i +: 4]);
    end
    if (err) begin
      exp_cyc   = 1;
      exp_price = 32'hFFFFF;
    end else begin
      exp_cyc   = 1 + 2 + dsum;
      exp_price = bcd_of(tbl[int'(id)] * dec_of({24'h0, q}, 2), 5);
    end

    ID = id; QTT = q; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; ID = 4'($urandom); QTT = 8'($urandom);
    cyc = 0; seen = 1'b0; busy_lost = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (!BUSY) busy_lost = 1'b1;
      cyc++;
      if (cyc == pulse_at) begin
        START = 1'b1; ID = 4'($urandom); QTT = 8'($urandom);
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    chk("done_seen",    32'(seen), 32'd1);
    chk("busy_cycles",  32'(cyc), 32'(exp_cyc));
    chk("busy_held",    32'(busy_lost), 32'd0);
    chk("busy_at_done", 32'(BUSY), 32'd1);
    chk("err",          32'(ERR), 32'(err));
    chk("price",        32'(PRICE), exp_price);

    if (clr_at_done) CLEAR = 1'b1;
    if (SUB_EN) begin
      if (clr_at_done) begin
        sub_m = 0; ovf_m = 1'b0;
      end else if (!err) begin
        sub_m += dec_of(exp_price, 5);
        if (sub_m > 99999) begin
          sub_m = 99999; ovf_m = 1'b1;
        end
      end
    end
    @(posedge CLK); #1;
    CLEAR = 1'b0;
    @(negedge CLK);
    chk("done_pulse", 32'(DONE), 32'd0);
    chk("idle_after", 32'(BUSY), 32'd0);
    chk("price_hold", 32'(PRICE), exp_price);
    chk("subtotal",   32'(SUBTOTAL), bcd_of(sub_m, 5));
    chk("ovf",        32'(OVF), 32'(ovf_m));
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    @(posedge CLK); #1;
    CLEAR = 1'b0;
    @(negedge CLK);
    if (SUB_EN) begin
      sub_m = 0; ovf_m = 1'b0;
    end
    chk("clear_sub", 32'(SUBTOTAL), bcd_of(sub_m, 5));
    chk("clear_ovf", 32'(OVF), 32'(ovf_m));
  endtask

  initial begin
    bit          saw;
    logic [3:0]  rid;
    logic [7:0]  rq;

    RESET_N = 1'b0; START = 1'b0; CLEAR = 1'b0; ID = '0; QTT = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_done",  32'(DONE), 32'd0);
    chk("rst_err",   32'(ERR), 32'd0);
    chk("rst_ovf",   32'(OVF), 32'd0);
    chk("rst_price", 32'(PRICE), 32'hFFFFF);
    chk("rst_sub",   32'(SUBTOTAL), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    run_line(4'd0, 8'h12, 0, 1'b0);
    run_line(4'd5, 8'h99, 3, 1'b0);
    run_line(4'd12, 8'h12, 0, 1'b0);
    run_line(4'd3, 8'h1A, 0, 1'b0);
    run_line(4'd7, 8'h00, 2, 1'b0);
    run_line(4'd11, 8'h90, 0, 1'b0);

    do_clear();
    run_line(4'd5, 8'h99, 0, 1'b0);
    run_line(4'd5, 8'h99, 0, 1'b0);
    run_line(4'd0, 8'h12, 0, 1'b1);

    // Reset while accumulating: no DONE may follow
    ID = 4'd5; QTT = 8'h99; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(BUSY), 32'd0);
    chk("mid_rst_done",  32'(DONE), 32'd0);
    chk("mid_rst_price", 32'(PRICE), 32'hFFFFF);
    chk("mid_rst_sub",   32'(SUBTOTAL), 32'd0);
    chk("mid_rst_ovf",   32'(OVF), 32'd0);
    sub_m = 0; ovf_m = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE || BUSY) saw = 1'b1;
    end
    chk("mid_rst_quiet", 32'(saw), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", 32'(BUSY), 32'd0);

    for (int n = 0; n < 30; n++) begin
      rid = 4'($urandom_range(0, 13));
      for (int d = 0; d < 2; d++)
        rq[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) do_clear();
      run_line(rid, rq, int'($urandom_range(0, 6)), $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_price_engine.md
LINE_PRICE_ENGINE -- requirements
Module: line_price_engine

Interface
REQ-001 The block SHALL have parameter PRICE_DIGITS, default 3, giving the BCD digits of a unit price.
REQ-002 The block SHALL have parameter QTY_DIGITS, default 2, giving the BCD digits of a quantity.
REQ-003 The block SHALL have parameter ID_W, default 4, giving the product ID width.
REQ-004 The block SHALL have parameter N_PRODUCTS, default 12, giving the number of valid IDs (0..N_PRODUCTS-1).
REQ-005 The block SHALL have parameter SUB_DIGITS, default PRICE_DIGITS+QTY_DIGITS+2, giving the BCD digits of the subtotal.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL provide these ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  async active-low reset.
- START  in  1  request; sampled only in IDLE.
- ID  in  ID_W  product ID.
- QTT  in  4*QTY_DIGITS  BCD quantity.
- CLEAR  in  1  zero the subtotal.
- BUSY  out  1  high in every non-IDLE state.
- DONE  out  1  one-cycle result strobe.
- ERR  out  1  qualifies DONE: invalid ID or non-BCD QTT.
- PRICE  out  4*(PRICE_DIGITS+QTY_DIGITS)  BCD line price.
- SUBTOTAL  out  4*SUB_DIGITS  BCD running total.
- OVF  out  1  sticky subtotal overflow.

Function
REQ-008 The block SHALL implement the FSM IDLE->LOAD->SHIFT<->ADD->DONE->IDLE.
REQ-009 In IDLE with START=1, the block SHALL capture ID and QTT and enter LOAD.
REQ-010 In LOAD, the block SHALL fetch the unit price from the package table and clear the accumulator.
REQ-011 If ID>=N_PRODUCTS, or any QTT digit is >9, LOAD SHALL go directly to DONE with ERR=1 and PRICE all-ones.
REQ-012 The block SHALL process QTT digits MSD first. For each digit it SHALL spend one SHIFT cycle (accumulator shifted left one BCD digit) and then d ADD cycles (accumulator += unit price, decimal-corrected per digit).
REQ-013 A valid request SHALL keep BUSY high for 1+QTY_DIGITS+sum(QTT digits) cycles before DONE. DONE SHALL be high for exactly one cycle, with BUSY=1.
REQ-014 PRICE SHALL update only on entry to DONE and SHALL hold its value until the next DONE.
REQ-015 The product SHALL never overflow, because its width is PRICE_DIGITS+QTY_DIGITS digits.
REQ-016 START while BUSY=1 SHALL be ignored, not queued. START may be re-accepted in the cycle after DONE.
REQ-017 ID and QTT changing during BUSY SHALL have no effect.
REQ-018 QTT=0 SHALL yield PRICE=0, ERR=0.

Reset
REQ-019 RESET_N=0 SHALL immediately force IDLE, BUSY=0, DONE=0, ERR=0, OVF=0, PRICE all-ones, SUBTOTAL=0 and the accumulator to 0.
REQ-020 Reset during any state SHALL abort the operation without producing DONE.

Configuration
REQ-021 With macro LINE_PRICE_SUBTOTAL_EN defined, the block SHALL add PRICE into SUBTOTAL in the cycle DONE=1 and ERR=0.
REQ-022 If that addition exceeds SUB_DIGITS, SUBTOTAL SHALL saturate to all nines and OVF SHALL set.
REQ-023 CLEAR=1 SHALL zero SUBTOTAL and OVF. CLEAR SHALL win over a simultaneous DONE, and that product SHALL be discarded from the subtotal.
REQ-024 Without LINE_PRICE_SUBTOTAL_EN, SUBTOTAL and OVF SHALL be constant 0, CLEAR SHALL be ignored, and no subtotal logic SHALL be synthesised.

Structure
REQ-025 A shared package price_pkg SHALL hold the state enum and the BCD unit-price table as a constant function indexed by ID. Invalid IDs SHALL return all-ones.
REQ-026 The per-digit decimal-correcting adder SHALL be a sub-module bcd_digit_add (a, b, cin -> sum, cout). It SHALL be instantiated in a generate chain by both the product and subtotal adders.

Verification
REQ-027 ID=0 (2.50 = 0x250), QTT=0x12: the bench SHALL see START accepted, 6 BUSY cycles, then DONE=1, ERR=0, PRICE=0x03000.
REQ-028 ID=5 (0x995), QTT=0x99: the bench SHALL see DONE after 21 BUSY cycles with PRICE=0x98505 and ERR=0.
REQ-029 ID=12, or QTT=0x1A: the bench SHALL see DONE after 1 BUSY cycle with ERR=1, PRICE=0xFFFFF and SUBTOTAL unchanged.
REQ-030 START pulsed mid-operation and reset asserted in ADD: the bench SHALL see the pulse ignored, and on reset BUSY=0 and PRICE=0xFFFFF at once with no DONE.
REQ-031 With LINE_PRICE_SUBTOTAL_EN and SUB_DIGITS=5, the bench SHALL see two ID=5/QTT=0x99 lines give SUBTOTAL=0x99999 with OVF=1. A following CLEAR coincident with DONE SHALL give SUBTOTAL=0 and OVF=0.
REQ-032 Without the macro, the bench SHALL see SUBTOTAL=0 and OVF=0 after REQ-027.
